// File: rtl/sram_pkg.sv
// Shared constants for the SRAM arbiter: FSM state encoding, op codes and default widths.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STAT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to
// the master that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported SRAM controller.
// Optional grant/conflict counters are built when SRAM_ARB_STATS_EN is defined.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef SRAM_ARB_STATS_EN
    ,
    parameter int STAT_W = DEF_STAT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_read_en,
    input  logic              m0_write_en,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_stall,
    input  logic              m1_read_en,
    input  logic              m1_write_en,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_stall,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] m0_grant_cnt,
    output logic [STAT_W-1:0] m1_grant_cnt,
    output logic [STAT_W-1:0] conflict_cnt
`endif
);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                op_q, op_d;
    logic                seen_busy_q, seen_busy_d;
    logic                mem_read_en_q, mem_read_en_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                m0_done_q, m0_done_d;
    logic                m1_done_q, m1_done_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
`ifdef SRAM_ARB_STATS_EN
    logic [STAT_W-1:0]   m0_grant_cnt_q, m0_grant_cnt_d;
    logic [STAT_W-1:0]   m1_grant_cnt_q, m1_grant_cnt_d;
    logic [STAT_W-1:0]   conflict_cnt_q, conflict_cnt_d;
`endif

    logic [1:0] req;
    logic       pick;
    logic       sel_write;

    assign req       = {m1_read_en | m1_write_en, m0_read_en | m0_write_en};
    // A master raising both enables is treated as a write.
    assign sel_write = pick ? m1_write_en : m0_write_en;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            op_q           <= OP_READ;
            seen_busy_q    <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_address_q  <= '0;
            mem_wdata_q    <= '0;
            m0_done_q      <= 1'b0;
            m1_done_q      <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
`ifdef SRAM_ARB_STATS_EN
            m0_grant_cnt_q <= '0;
            m1_grant_cnt_q <= '0;
            conflict_cnt_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            op_q           <= op_d;
            seen_busy_q    <= seen_busy_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            mem_address_q  <= mem_address_d;
            mem_wdata_q    <= mem_wdata_d;
            m0_done_q      <= m0_done_d;
            m1_done_q      <= m1_done_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
`ifdef SRAM_ARB_STATS_EN
            m0_grant_cnt_q <= m0_grant_cnt_d;
            m1_grant_cnt_q <= m1_grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        op_d           = op_q;
        seen_busy_d    = seen_busy_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        mem_address_d  = mem_address_q;
        mem_wdata_d    = mem_wdata_q;
        m0_done_d      = 1'b0;
        m1_done_d      = 1'b0;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;
`ifdef SRAM_ARB_STATS_EN
        m0_grant_cnt_d = m0_grant_cnt_q;
        m1_grant_cnt_d = m1_grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef SRAM_ARB_STATS_EN
                if (mem_ready && (&req))
                    conflict_cnt_d = conflict_cnt_q + 1'b1;
`endif
                if (mem_ready && (|req)) begin
                    grant_d        = pick;
                    op_d           = sel_write ? OP_WRITE : OP_READ;
                    mem_address_d  = pick ? m1_address : m0_address;
                    mem_wdata_d    = pick ? m1_wdata : m0_wdata;
                    mem_read_en_d  = ~sel_write;
                    mem_write_en_d = sel_write;
                    seen_busy_d    = 1'b0;
                    state_d        = ST_ISSUE;
`ifdef SRAM_ARB_STATS_EN
                    if (!pick && (m0_grant_cnt_q != '1))
                        m0_grant_cnt_d = m0_grant_cnt_q + 1'b1;
                    if (pick && (m1_grant_cnt_q != '1))
                        m1_grant_cnt_d = m1_grant_cnt_q + 1'b1;
`endif
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Completion needs a ready that first dropped; a constant ready means nothing.
                if (!mem_ready) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = ST_DONE;
                    if (grant_q) begin
                        m1_done_d = 1'b1;
                        if (op_q == OP_READ)
                            m1_rdata_d = mem_rdata;
                    end else begin
                        m0_done_d = 1'b1;
                        if (op_q == OP_READ)
                            m0_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_address  = mem_address_q;
    assign mem_wdata    = mem_wdata_q;
    assign m0_done      = m0_done_q;
    assign m1_done      = m1_done_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign m0_stall     = (m0_read_en | m0_write_en) & ~m0_done_q;
    assign m1_stall     = (m1_read_en | m1_write_en) & ~m1_done_q;
`ifdef SRAM_ARB_STATS_EN
    assign m0_grant_cnt = m0_grant_cnt_q;
    assign m1_grant_cnt = m1_grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
